// File: rtl/uart_link_pkg.sv
// Shared encodings and oversampling constants for the UART link core.
package uart_link_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; an empty FIFO presents zero on rd_data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/uart_link_core.sv
// UART link for the debugger path: shared 16x tick, TX/RX serialisers, RX and TX FIFOs.
module uart_link_core
  import uart_link_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_bit,
  output logic                 o_tx_bit,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 is_tx_push,
  output logic                 o_tx_full,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_empty,
  input  logic                 is_rx_pop,
  input  logic                 is_err_clr,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int       TW        = $clog2(CLK_DIV);
  localparam int       BW        = $clog2(DATA_BITS);
  localparam logic     PAR_ODD   = (PARITY == PARITY_ODD);
  localparam logic     HAS_PAR   = (PARITY != PARITY_NONE);
  localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] MID_TICK  = 5'(MID_SAMPLE);
  localparam logic [4:0] STOP_LAST = 5'(OVERSAMPLE * STOP_BITS - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // ---------------- receive path ----------------
  logic                 rx_meta, rx_sync;
  rx_state_e            rx_state;
  logic [4:0]           rx_ticks;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_fail;
  logic                 rx_full, rx_push;
  logic                 rx_stop_sample, rx_good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx_bit;
      rx_sync <= rx_meta;
    end
  end

  assign rx_stop_sample = (rx_state == RX_STOP) && tick && (rx_ticks == LAST_TICK);
  assign rx_good        = rx_stop_sample && rx_sync && !rx_par_fail;
  assign rx_push        = rx_good && !rx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      rx_ticks    <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_par_fail <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: if (!rx_sync) begin
          rx_state    <= RX_START;
          rx_ticks    <= '0;
          rx_par_fail <= 1'b0;
        end
        RX_START: if (tick) begin
          if (rx_ticks == MID_TICK) begin
            // Line back high by mid start bit: treat as a glitch.
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            rx_ticks <= '0;
            rx_idx   <= '0;
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        RX_DATA: if (tick) begin
          if (rx_ticks == LAST_TICK) begin
            rx_ticks <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == BW'(DATA_BITS - 1)) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            else rx_idx <= rx_idx + BW'(1);
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        RX_PARITY: if (tick) begin
          if (rx_ticks == LAST_TICK) begin
            rx_ticks    <= '0;
            rx_par_fail <= rx_sync != ((^rx_shift) ^ PAR_ODD);
            rx_state    <= RX_STOP;
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        RX_STOP: if (tick) begin
          if (rx_ticks == LAST_TICK) begin
            rx_ticks <= '0;
            rx_state <= RX_IDLE;
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (rx_stop_sample && !rx_sync)                o_frame_err  <= 1'b1;
      else if (is_err_clr)                           o_frame_err  <= 1'b0;
      if (rx_stop_sample && rx_sync && rx_par_fail)  o_parity_err <= 1'b1;
      else if (is_err_clr)                           o_parity_err <= 1'b0;
      if (rx_good && rx_full)                        o_overrun    <= 1'b1;
      else if (is_err_clr)                           o_overrun    <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push),
    .wr_data (rx_shift),
    .full    (rx_full),
    .pop     (is_rx_pop),
    .rd_data (o_rx_data),
    .empty   (o_rx_empty)
  );

  // ---------------- transmit path ----------------
  tx_state_e            tx_state;
  logic [4:0]           tx_ticks;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_empty, tx_pop;

  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop = !tx_empty && tick &&
                  ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_ticks == STOP_LAST)));
  assign o_tx_busy = (tx_state != TX_IDLE) || !tx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_ticks <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      o_tx_bit <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_ticks <= '0;
      tx_shift <= tx_head;
      tx_par   <= (^tx_head) ^ PAR_ODD;
      o_tx_bit <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: o_tx_bit <= 1'b1;
        TX_START: if (tick) begin
          if (tx_ticks == LAST_TICK) begin
            tx_ticks <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
            o_tx_bit <= tx_shift[0];
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        TX_DATA: if (tick) begin
          if (tx_ticks == LAST_TICK) begin
            tx_ticks <= '0;
            if (tx_idx == BW'(DATA_BITS - 1)) begin
              tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
              o_tx_bit <= HAS_PAR ? tx_par : 1'b1;
            end else begin
              tx_idx   <= tx_idx + BW'(1);
              tx_shift <= tx_shift >> 1;
              o_tx_bit <= tx_shift[1];
            end
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        TX_PARITY: if (tick) begin
          if (tx_ticks == LAST_TICK) begin
            tx_ticks <= '0;
            tx_state <= TX_STOP;
            o_tx_bit <= 1'b1;
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        TX_STOP: if (tick) begin
          if (tx_ticks == STOP_LAST) begin
            tx_ticks <= '0;
            tx_state <= TX_IDLE;
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (is_tx_push),
    .wr_data (i_tx_data),
    .full    (o_tx_full),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

endmodule

// File: tb/tb_uart_link_core.sv
// Directed bench for uart_link_core: even parity, 4-deep FIFOs, optional TX->RX loopback.
module tb_uart_link_core;
  import uart_link_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int DATA_BITS  = 8;
  localparam int PAR_MODE   = 2;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       o_tx_bit;
  logic [7:0] i_tx_data;
  logic       is_tx_push;
  logic       o_tx_full, o_tx_busy;
  logic [7:0] o_rx_data;
  logic       o_rx_empty;
  logic       is_rx_pop, is_err_clr;
  logic       o_parity_err, o_frame_err, o_overrun;
  logic       loopback, drv_rx, rx_line;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  assign rx_line = loopback ? o_tx_bit : drv_rx;

  always #5 clk = ~clk;

  uart_link_core #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY(PAR_MODE),
    .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .i_rx_bit(rx_line), .o_tx_bit(o_tx_bit),
    .i_tx_data(i_tx_data), .is_tx_push(is_tx_push), .o_tx_full(o_tx_full),
    .o_tx_busy(o_tx_busy), .o_rx_data(o_rx_data), .o_rx_empty(o_rx_empty),
    .is_rx_pop(is_rx_pop), .is_err_clr(is_err_clr), .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    i_tx_data  = d;
    is_tx_push = 1'b1;
    @(negedge clk);
    is_tx_push = 1'b0;
  endtask

  task automatic clear_errors();
    is_err_clr = 1'b1;
    @(negedge clk);
    is_err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx_low(input int bound);
    int w = 0;
    while (o_tx_bit !== 1'b0 && w < bound) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", o_tx_bit, 0);
  endtask

  // Checks one looped-back frame bit by bit against the bench's own framing.
  task automatic check_tx_frame(input logic [7:0] data, input int bound);
    logic [10:0] fr;
    fr = {1'b1, ^data, data, 1'b0};
    wait_tx_low(bound);
    repeat (BIT_CLKS - 1) @(negedge clk);
    check("tx_start_len", o_tx_bit, 0);
    @(negedge clk);
    check("tx_start_end", o_tx_bit, fr[1]);
    for (int i = 1; i <= 10; i++) begin
      repeat (BIT_CLKS / 2) @(negedge clk);
      check($sformatf("tx_bit%0d", i), o_tx_bit, fr[i]);
      if (i < 10) repeat (BIT_CLKS / 2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop_bit);
    drv_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv_rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    drv_rx = par;
    repeat (BIT_CLKS) @(negedge clk);
    drv_rx = stop_bit;
    // A short low stop bit keeps its tail from looking like a real start.
    repeat (stop_bit ? BIT_CLKS : 44) @(negedge clk);
    drv_rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic drain_rx(input int bound);
    while (exp_q.size() > 0) begin
      int w = 0;
      while (o_rx_empty && w < bound) begin
        @(negedge clk);
        w++;
      end
      check("rx_arrive", o_rx_empty, 0);
      if (o_rx_empty) begin
        exp_q.delete();
        return;
      end
      check("rx_data", o_rx_data, exp_q.pop_front());
      is_rx_pop = 1'b1;
      @(negedge clk);
      is_rx_pop = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    rst = 1'b1; loopback = 1'b1; drv_rx = 1'b1;
    i_tx_data = '0; is_tx_push = 1'b0; is_rx_pop = 1'b0; is_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_bit", o_tx_bit, 1);
    check("rst_tx_full", o_tx_full, 0);
    check("rst_tx_busy", o_tx_busy, 0);
    check("rst_rx_empty", o_rx_empty, 1);
    check("rst_rx_data", o_rx_data, 0);
    check("rst_flags", {o_parity_err, o_frame_err, o_overrun}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback 0xA5, start edge within CLK_DIV+2 clocks of the push.
    push_tx(8'hA5);
    exp_q.push_back(8'hA5);
    check_tx_frame(8'hA5, CLK_DIV + 2);
    drain_rx(400);
    check("a5_flags", {o_parity_err, o_frame_err, o_overrun}, 0);
    repeat (60) @(negedge clk);

    // 0x07 has odd weight, so the even parity bit is 1.
    push_tx(8'h07);
    exp_q.push_back(8'h07);
    check_tx_frame(8'h07, CLK_DIV + 2);
    drain_rx(400);
    check("07_parity_ok", o_parity_err, 0);
    repeat (60) @(negedge clk);
    loopback = 1'b0;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("bad_parity_flag", o_parity_err, 1);
    check("bad_parity_dropped", o_rx_empty, 1);
    clear_errors();
    check("parity_cleared", o_parity_err, 0);

    // 20-clock glitch is shorter than half a start bit.
    drv_rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_start", dut.rx_state, RX_START);
    repeat (10) @(negedge clk);
    drv_rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_idle", dut.rx_state, RX_IDLE);
    check("glitch_empty", o_rx_empty, 1);
    check("glitch_flags", {o_parity_err, o_frame_err, o_overrun}, 0);

    // Framing error: 0x3C with the stop bit low.
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    check("frame_err_set", o_frame_err, 1);
    check("frame_err_parity", o_parity_err, 0);
    check("frame_err_dropped", o_rx_empty, 1);
    clear_errors();
    check("frame_err_cleared", o_frame_err, 0);

    // Five frames into a 4-deep RX FIFO: the fifth is dropped.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), ^(8'(i)), 1'b1);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    repeat (20) @(negedge clk);
    check("overrun_set", o_overrun, 1);
    check("overrun_other_flags", {o_parity_err, o_frame_err}, 0);
    drain_rx(10);
    check("overrun_drained", o_rx_empty, 1);
    clear_errors();

    // TX FIFO fill: first byte in flight, four more fill the FIFO, the sixth is dropped.
    loopback = 1'b1;
    push_tx(8'h11);
    exp_q.push_back(8'h11);
    wait_tx_low(CLK_DIV + 2);
    push_tx(8'h22); push_tx(8'h33); push_tx(8'h44); push_tx(8'h55);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    check("tx_full_set", o_tx_full, 1);
    check("tx_busy_set", o_tx_busy, 1);
    push_tx(8'h66);
    check("tx_full_hold", o_tx_full, 1);
    drain_rx(1000);
    repeat (800) @(negedge clk);
    check("tx_sixth_dropped", o_rx_empty, 1);
    check("tx_done_busy", o_tx_busy, 0);
    check("tx_fill_flags", {o_parity_err, o_frame_err, o_overrun}, 0);

    // Reset mid-frame with more bytes queued.
    push_tx(8'h5A); push_tx(8'h6B); push_tx(8'h7C);
    wait_tx_low(CLK_DIV + 2);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_bit", o_tx_bit, 1);
    check("mid_rst_busy", o_tx_busy, 0);
    check("mid_rst_full", o_tx_full, 0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (1500) begin
      @(negedge clk);
      if (o_tx_bit !== 1'b1) lows++;
    end
    check("post_rst_line_idle", lows, 0);
    check("post_rst_busy", o_tx_busy, 0);
    check("post_rst_rx_empty", o_rx_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
